// File: rtl/time_set_controller.sv
// Mode and increment sequencer for the wall clock: owns the one-second prescaler,
// the RUN/SET_HOUR/SET_MIN mode machine, press-and-hold auto-repeat and the set-field blink mask.
module time_set_controller #(
  parameter int unsigned TICK_DIV      = 32'd100_000_000,
  parameter int unsigned BLINK_DIV     = 32'd50_000_000,
  parameter int unsigned HOLD_CYCLES   = 32'd50_000_000,
  parameter int unsigned REPEAT_CYCLES = 32'd25_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       ResetButton,
  input  logic       MODE_BTN,
  input  logic       INC_BTN,
  output logic       sec_tick,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       clr_secs,
  output logic [3:0] digit_blank,
  output logic [1:0] mode
);

  localparam int unsigned TICK_W  = $clog2(TICK_DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES);
  localparam int unsigned RPT_W   = $clog2(REPEAT_CYCLES);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 32'd1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 32'd1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 32'd1);
  localparam logic [RPT_W-1:0]   RPT_LAST   = RPT_W'(REPEAT_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic                 mode_prev_q, mode_prev_d;
  logic                 inc_prev_q, inc_prev_d;
  logic [TICK_W-1:0]    presc_q, presc_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q, blink_phase_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [RPT_W-1:0]     rpt_cnt_q, rpt_cnt_d;
  logic                 rpt_active_q, rpt_active_d;
  logic                 sec_tick_q, sec_tick_d;
  logic                 inc_min_q, inc_min_d;
  logic                 inc_hour_q, inc_hour_d;
  logic                 clr_secs_q, clr_secs_d;
  logic [3:0]           digit_blank_q, digit_blank_d;

  logic                 mode_rise;
  logic                 inc_rise;
  logic                 set_active;
  logic                 inc_pulse;

  // Button edge detection and mode sequencing; a mode edge always outranks an increment.
  always_comb begin
    mode_prev_d = MODE_BTN;
    inc_prev_d  = INC_BTN;
    mode_rise   = MODE_BTN & ~mode_prev_q;
    inc_rise    = INC_BTN & ~inc_prev_q;
    state_d     = state_q;
    clr_secs_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mode_rise) state_d = ST_SET_HOUR;
        else           state_d = ST_RUN;
      end
      ST_SET_HOUR: begin
        if (mode_rise) state_d = ST_SET_MIN;
        else           state_d = ST_SET_HOUR;
      end
      ST_SET_MIN: begin
        if (mode_rise) begin
          state_d    = ST_RUN;
          clr_secs_d = 1'b1;
        end else begin
          state_d    = ST_SET_MIN;
          clr_secs_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        clr_secs_d = 1'b0;
      end
    endcase
    set_active = ((state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN)) && !mode_rise;
  end

  // Seconds prescaler: runs only while staying in RUN, otherwise parked at zero.
  always_comb begin
    presc_d    = '0;
    sec_tick_d = 1'b0;
    if ((state_q == ST_RUN) && !mode_rise) begin
      if (presc_q == TICK_LAST) begin
        presc_d    = '0;
        sec_tick_d = 1'b1;
      end else begin
        presc_d    = presc_q + TICK_W'(1'b1);
        sec_tick_d = 1'b0;
      end
    end else begin
      presc_d    = '0;
      sec_tick_d = 1'b0;
    end
  end

  // Press-and-hold: the hold counter saturates at its last value once repeating starts.
  always_comb begin
    hold_cnt_d   = '0;
    rpt_cnt_d    = '0;
    rpt_active_d = 1'b0;
    inc_pulse    = 1'b0;
    if (set_active && INC_BTN) begin
      if (inc_rise) begin
        inc_pulse = 1'b1;
      end else if (rpt_active_q) begin
        hold_cnt_d   = hold_cnt_q;
        rpt_active_d = 1'b1;
        if (rpt_cnt_q == RPT_LAST) begin
          inc_pulse = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          inc_pulse = 1'b0;
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1'b1);
        end
      end else if (hold_cnt_q == HOLD_LAST) begin
        inc_pulse    = 1'b1;
        hold_cnt_d   = hold_cnt_q;
        rpt_active_d = 1'b1;
        rpt_cnt_d    = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1'b1);
      end
    end else begin
      inc_pulse = 1'b0;
    end
  end

  // Increment routing, blink phase and the blank mask for the field under edit.
  always_comb begin
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    inc_hour_d    = 1'b0;
    inc_min_d     = 1'b0;
    digit_blank_d = 4'b0000;
    if (set_active) begin
      inc_hour_d = inc_pulse && (state_q == ST_SET_HOUR);
      inc_min_d  = inc_pulse && (state_q == ST_SET_MIN);
      if (inc_pulse) begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1'b1);
        blink_phase_d = blink_phase_q;
      end
    end else begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end
    if (blink_phase_d) begin
      case (state_d)
        ST_SET_HOUR: digit_blank_d = 4'b1100;
        ST_SET_MIN:  digit_blank_d = 4'b0011;
        default:     digit_blank_d = 4'b0000;
      endcase
    end else begin
      digit_blank_d = 4'b0000;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK100MHZ) begin
    if (ResetButton) begin
      state_q       <= ST_RUN;
      mode_prev_q   <= 1'b0;
      inc_prev_q    <= 1'b0;
      presc_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      hold_cnt_q    <= '0;
      rpt_cnt_q     <= '0;
      rpt_active_q  <= 1'b0;
      sec_tick_q    <= 1'b0;
      inc_min_q     <= 1'b0;
      inc_hour_q    <= 1'b0;
      clr_secs_q    <= 1'b0;
      digit_blank_q <= 4'b0000;
    end else begin
      state_q       <= state_d;
      mode_prev_q   <= mode_prev_d;
      inc_prev_q    <= inc_prev_d;
      presc_q       <= presc_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      hold_cnt_q    <= hold_cnt_d;
      rpt_cnt_q     <= rpt_cnt_d;
      rpt_active_q  <= rpt_active_d;
      sec_tick_q    <= sec_tick_d;
      inc_min_q     <= inc_min_d;
      inc_hour_q    <= inc_hour_d;
      clr_secs_q    <= clr_secs_d;
      digit_blank_q <= digit_blank_d;
    end
  end

  assign sec_tick    = sec_tick_q;
  assign inc_min     = inc_min_q;
  assign inc_hour    = inc_hour_q;
  assign clr_secs    = clr_secs_q;
  assign digit_blank = digit_blank_q;
  assign mode        = state_q;

endmodule
